// File: rtl/pmci_host_csr_rsp.sv
// PMCI host CSR responder: DFH, scratchpad, FBM_AR and status behind an Avalon-MM slave.
// Optional build macro PMCI_CSR_UNUSED_SLVERR_EN: unused-offset reads respond SLVERR instead of OKAY.
module pmci_host_csr_rsp #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ADDR_W       = 9,
    parameter logic [63:0] DFH_VALUE    = 64'h3000_0000_1000_0012
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] avs_address_i,
    input  logic              avs_read_i,
    input  logic              avs_write_i,
    input  logic [63:0]       avs_writedata_i,
    input  logic [7:0]        avs_byteenable_i,
    output logic              avs_waitrequest_o,
    output logic [63:0]       avs_readdata_o,
    output logic              avs_readdatavalid_o,
    output logic [1:0]        avs_response_o,
    input  logic [63:0]       status_in_i,
    output logic [31:0]       fbm_ar_o,
    output logic              fbm_ar_wr_o
);

    typedef enum logic {
        ST_IDLE,
        ST_RD_BUSY
    } state_e;

    localparam int unsigned       CNT_W       = $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_W-1:0] OFF_DFH     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFF_SCRATCH = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFF_FBM_AR  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] OFF_STATUS  = ADDR_W'(3);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
`ifdef PMCI_CSR_UNUSED_SLVERR_EN
    localparam logic [1:0]        RESP_UNUSED = 2'b10;
`else
    localparam logic [1:0]        RESP_UNUSED = 2'b00;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        scratch_q, scratch_d;
    logic [31:0]        fbm_ar_q, fbm_ar_d;
    logic               fbm_ar_wr_q, fbm_ar_wr_d;
    logic               pipe_vld_q  [READ_LATENCY];
    logic [63:0]        pipe_data_q [READ_LATENCY];
    logic [1:0]         pipe_resp_q [READ_LATENCY];
    logic               rvalid_q;
    logic [63:0]        rdata_q;
    logic [1:0]         resp_q;

    logic               rd_acc;
    logic               wr_acc;
    logic [63:0]        rd_data;
    logic [1:0]         rd_resp;

    // Busy ends in the read-return cycle (counter at zero), so a new request can land there.
    assign avs_waitrequest_o = rst_i || ((state_q == ST_RD_BUSY) && (cnt_q != '0));
    assign rd_acc            = avs_read_i  && !avs_waitrequest_o;
    assign wr_acc            = avs_write_i && !avs_waitrequest_o;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (avs_address_i)
            OFF_DFH:     rd_data = DFH_VALUE;
            OFF_SCRATCH: rd_data = scratch_q;
            OFF_FBM_AR:  rd_data = {32'h0, fbm_ar_q};
            OFF_STATUS:  rd_data = status_in_i;
            default:     rd_resp = RESP_UNUSED;
        endcase
    end

    always_comb begin
        scratch_d   = scratch_q;
        fbm_ar_d    = fbm_ar_q;
        fbm_ar_wr_d = 1'b0;
        if (wr_acc) begin
            case (avs_address_i)
                OFF_SCRATCH: begin
                    for (int i = 0; i < 8; i++) begin
                        if (avs_byteenable_i[i]) scratch_d[8*i +: 8] = avs_writedata_i[8*i +: 8];
                    end
                end
                OFF_FBM_AR: begin
                    for (int i = 0; i < 4; i++) begin
                        if (avs_byteenable_i[i]) fbm_ar_d[8*i +: 8] = avs_writedata_i[8*i +: 8];
                    end
                    fbm_ar_wr_d = |avs_byteenable_i[3:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_acc) begin
                    state_d = ST_RD_BUSY;
                    cnt_d   = CNT_W'(READ_LATENCY);
                end
            end
            ST_RD_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rd_acc) begin
                    cnt_d = CNT_W'(READ_LATENCY);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            scratch_q   <= '0;
            fbm_ar_q    <= '0;
            fbm_ar_wr_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
            // NOTE: the read pipeline is small and flushed on reset, so its data stages are cleared too.
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_data_q[i] <= '0;
                pipe_resp_q[i] <= RESP_OKAY;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            scratch_q      <= scratch_d;
            fbm_ar_q       <= fbm_ar_d;
            fbm_ar_wr_q    <= fbm_ar_wr_d;
            pipe_vld_q[0]  <= rd_acc;
            pipe_data_q[0] <= rd_data;
            pipe_resp_q[0] <= rd_resp;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
                pipe_resp_q[i] <= pipe_resp_q[i-1];
            end
            rvalid_q <= pipe_vld_q[READ_LATENCY-1];
            if (pipe_vld_q[READ_LATENCY-1]) begin
                rdata_q <= pipe_data_q[READ_LATENCY-1];
                resp_q  <= pipe_resp_q[READ_LATENCY-1];
            end
        end
    end

    assign avs_readdata_o      = rdata_q;
    assign avs_readdatavalid_o = rvalid_q;
    assign avs_response_o      = resp_q;
    assign fbm_ar_o            = fbm_ar_q;
    assign fbm_ar_wr_o         = fbm_ar_wr_q;

endmodule

// File: tb/tb_pmci_host_csr_rsp.sv
// Self-checking bench for pmci_host_csr_rsp: directed register-map scenarios plus randomized
// traffic scored against a register-level reference model.
module tb_pmci_host_csr_rsp;

    localparam int unsigned RL  = 2;
    localparam int unsigned AW  = 9;
    localparam logic [63:0] DFH = 64'h3000_0000_1000_0012;
`ifdef PMCI_CSR_UNUSED_SLVERR_EN
    localparam logic [1:0] UNUSED_RESP = 2'b10;
`else
    localparam logic [1:0] UNUSED_RESP = 2'b00;
`endif

    logic          clk;
    logic          rst;
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [63:0]   avs_writedata;
    logic [7:0]    avs_byteenable;
    logic          avs_waitrequest;
    logic [63:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic [1:0]    avs_response;
    logic [63:0]   status_in;
    logic [31:0]   fbm_ar;
    logic          fbm_ar_wr;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural register contents only.
    logic [63:0] m_scratch;
    logic [31:0] m_fbm;

    pmci_host_csr_rsp #(
        .READ_LATENCY (RL),
        .ADDR_W       (AW),
        .DFH_VALUE    (DFH)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .avs_address_i       (avs_address),
        .avs_read_i          (avs_read),
        .avs_write_i         (avs_write),
        .avs_writedata_i     (avs_writedata),
        .avs_byteenable_i    (avs_byteenable),
        .avs_waitrequest_o   (avs_waitrequest),
        .avs_readdata_o      (avs_readdata),
        .avs_readdatavalid_o (avs_readdatavalid),
        .avs_response_o      (avs_response),
        .status_in_i         (status_in),
        .fbm_ar_o            (fbm_ar),
        .fbm_ar_wr_o         (fbm_ar_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] m_read_data(input logic [AW-1:0] a, input logic [63:0] st);
        case (a)
            0:       return DFH;
            1:       return m_scratch;
            2:       return {32'h0, m_fbm};
            3:       return st;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [1:0] m_read_resp(input logic [AW-1:0] a);
        return (a <= 3) ? 2'b00 : UNUSED_RESP;
    endfunction

    function automatic bit m_pulse(input logic [AW-1:0] a, input logic [7:0] be);
        return (a == 2) && (be[3:0] != 4'h0);
    endfunction

    task automatic m_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
        for (int i = 0; i < 8; i++) begin
            if (be[i] && a == 1) m_scratch[8*i +: 8] = d[8*i +: 8];
            if (be[i] && a == 2 && i < 4) m_fbm[8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // One bus transaction; returns what the DUT produced, callers compare against the model.
    task automatic do_op(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [63:0] d, input logic [7:0] be,
                         output logic [63:0] o_data, output logic [1:0] o_resp,
                         output int o_lat, output bit o_pulse, output bit o_timeout);
        int n;
        o_data = '0; o_resp = '0; o_lat = -1; o_pulse = 1'b0; o_timeout = 1'b0;
        @(negedge clk);
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d; avs_byteenable = be;
        n = 0;
        while (avs_waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (avs_waitrequest) begin
            o_timeout = 1'b1;
            avs_read = 1'b0; avs_write = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        avs_read = 1'b0; avs_write = 1'b0;
        @(negedge clk);
        o_pulse = fbm_ar_wr;
        if (rd) begin
            n = 0;
            while (!avs_readdatavalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!avs_readdatavalid) o_timeout = 1'b1;
            else begin
                o_data = avs_readdata; o_resp = avs_response; o_lat = n;
            end
        end
    endtask

    task automatic test_reset();
        logic [63:0] d; logic [1:0] r; int lat; bit p, to;
        rst = 1'b1; avs_read = 0; avs_write = 0; avs_address = '0;
        avs_writedata = '0; avs_byteenable = '0; status_in = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        checks++;
        if (avs_waitrequest !== 1'b1) begin
            failures++; $display("FAIL reset_waitreq: got %b expected 1", avs_waitrequest);
        end
        checks++;
        if ({avs_readdatavalid, avs_readdata, avs_response, fbm_ar, fbm_ar_wr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got vld=%b data=%h resp=%b fbm=%h wr=%b expected all 0",
                     avs_readdatavalid, avs_readdata, avs_response, fbm_ar, fbm_ar_wr);
        end
        rst = 1'b0;
        m_scratch = '0; m_fbm = '0;
        @(negedge clk);
        checks++;
        if (avs_waitrequest !== 1'b0) begin
            failures++; $display("FAIL release_waitreq: got %b expected 0", avs_waitrequest);
        end
        for (int a = 0; a < 3; a++) begin
            do_op(1, 0, AW'(a), '0, '0, d, r, lat, p, to);
            checks++;
            if (to || d !== m_read_data(AW'(a), status_in) || r !== 2'b00 || lat != int'(RL)) begin
                failures++;
                $display("FAIL reset_read_%0d: got data=%h resp=%b lat=%0d to=%b expected data=%h resp=00 lat=%0d",
                         a, d, r, lat, to, m_read_data(AW'(a), status_in), RL);
            end
        end
    endtask

    task automatic test_fbm_ar();
        logic [63:0] d; logic [1:0] r; int lat; bit p, to;
        do_op(0, 1, 2, 64'hBAAD_BEEF, 8'hFF, d, r, lat, p, to);
        m_write(2, 64'hBAAD_BEEF, 8'hFF);
        checks++;
        if (to || p !== 1'b1 || fbm_ar !== m_fbm) begin
            failures++; $display("FAIL fbm_pulse: got pulse=%b fbm=%h expected pulse=1 fbm=%h", p, fbm_ar, m_fbm);
        end
        @(negedge clk);
        checks++;
        if (fbm_ar_wr !== 1'b0) begin
            failures++; $display("FAIL fbm_pulse_width: got %b expected 0", fbm_ar_wr);
        end
        do_op(1, 0, 2, '0, '0, d, r, lat, p, to);
        checks++;
        if (to || d !== 64'h0000_0000_BAAD_BEEF || r !== 2'b00 || lat != int'(RL)) begin
            failures++;
            $display("FAIL fbm_read: got data=%h resp=%b lat=%0d expected data=00000000baadbeef resp=00 lat=%0d",
                     d, r, lat, RL);
        end
        do_op(0, 1, 2, 64'h1234_5678_0000_0000, 8'hF0, d, r, lat, p, to);
        m_write(2, 64'h1234_5678_0000_0000, 8'hF0);
        checks++;
        if (to || p !== 1'b0 || fbm_ar !== m_fbm) begin
            failures++; $display("FAIL fbm_upper_lanes: got pulse=%b fbm=%h expected pulse=0 fbm=%h", p, fbm_ar, m_fbm);
        end
    endtask

    task automatic test_byte_lanes();
        logic [63:0] d; logic [1:0] r; int lat; bit p, to;
        do_op(0, 1, 1, 64'h1122_3344_5566_7788, 8'hFF, d, r, lat, p, to);
        m_write(1, 64'h1122_3344_5566_7788, 8'hFF);
        do_op(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, d, r, lat, p, to);
        m_write(1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        do_op(1, 0, 1, '0, '0, d, r, lat, p, to);
        checks++;
        if (to || d !== 64'h1122_3344_FFFF_FFFF || r !== 2'b00) begin
            failures++; $display("FAIL byte_lanes: got data=%h resp=%b expected data=11223344ffffffff resp=00", d, r);
        end
    endtask

    task automatic test_unused();
        logic [63:0] d; logic [1:0] r; int lat; bit p, to;
        do_op(0, 1, 9'h1D, 64'hBAAD_BEEF, 8'hFF, d, r, lat, p, to);
        do_op(1, 0, 9'h1D, '0, '0, d, r, lat, p, to);
        checks++;
        if (to || d !== 64'h0 || r !== UNUSED_RESP || lat != int'(RL)) begin
            failures++; $display("FAIL unused_1d: got data=%h resp=%b lat=%0d expected data=0 resp=%b", d, r, lat, UNUSED_RESP);
        end
        do_op(1, 0, 9'h1FF, '0, '0, d, r, lat, p, to);
        checks++;
        if (to || d !== 64'h0 || r !== UNUSED_RESP) begin
            failures++; $display("FAIL unused_1ff: got data=%h resp=%b expected data=0 resp=%b", d, r, UNUSED_RESP);
        end
        do_op(1, 0, 1, '0, '0, d, r, lat, p, to);
        checks++;
        if (to || d !== m_scratch) begin
            failures++; $display("FAIL unused_no_alias: got %h expected %h", d, m_scratch);
        end
    endtask

    task automatic test_write_then_read();
        logic [63:0] wd;
        int n;
        wd = {$urandom, $urandom};
        @(negedge clk);
        avs_address = 1; avs_write = 1'b1; avs_writedata = wd; avs_byteenable = 8'hFF;
        @(posedge clk);
        #1;
        m_write(1, wd, 8'hFF);
        avs_write = 1'b0; avs_read = 1'b1;
        @(negedge clk);
        checks++;
        if (avs_waitrequest !== 1'b0) begin
            failures++; $display("FAIL wr_rd_waitreq: got %b expected 0", avs_waitrequest);
        end
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        n = 0;
        @(negedge clk);
        while (!avs_readdatavalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!avs_readdatavalid || avs_readdata !== m_scratch) begin
            failures++; $display("FAIL wr_rd_order: got vld=%b data=%h expected %h", avs_readdatavalid, avs_readdata, m_scratch);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d; logic [1:0] r; int lat; bit p, to;
        bit exp_pulse;
        exp_pulse = 1'b0;
        @(negedge clk);
        avs_write = 1'b1;
        for (int i = 0; i < 6; i++) begin
            avs_address    = AW'(1 + (i % 2));
            avs_writedata  = {$urandom, $urandom};
            avs_byteenable = 8'($urandom);
            checks++;
            if (avs_waitrequest !== 1'b0 || fbm_ar_wr !== exp_pulse) begin
                failures++;
                $display("FAIL b2b_write_%0d: got waitreq=%b pulse=%b expected waitreq=0 pulse=%b",
                         i, avs_waitrequest, fbm_ar_wr, exp_pulse);
            end
            @(posedge clk);
            m_write(avs_address, avs_writedata, avs_byteenable);
            exp_pulse = m_pulse(avs_address, avs_byteenable);
            @(negedge clk);
        end
        avs_write = 1'b0;
        checks++;
        if (fbm_ar_wr !== exp_pulse || fbm_ar !== m_fbm) begin
            failures++; $display("FAIL b2b_last: got pulse=%b fbm=%h expected pulse=%b fbm=%h", fbm_ar_wr, fbm_ar, exp_pulse, m_fbm);
        end
        do_op(1, 0, 1, '0, '0, d, r, lat, p, to);
        checks++;
        if (to || d !== m_scratch) begin
            failures++; $display("FAIL b2b_scratch: got %h expected %h", d, m_scratch);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] q[$];
        logic [63:0] exp;
        int busy_left, seen, accepted;
        busy_left = 0; seen = 0; accepted = 0;
        @(negedge clk);
        avs_address = 3; avs_read = 1'b1;
        for (int c = 0; c < 6; c++) begin
            status_in = {$urandom, $urandom};
            checks++;
            if (avs_waitrequest !== (busy_left > 0)) begin
                failures++; $display("FAIL bp_waitreq_%0d: got %b expected %b", c, avs_waitrequest, busy_left > 0);
            end
            if (avs_readdatavalid) begin
                seen++;
                exp = (q.size() > 0) ? q.pop_front() : 64'hx;
                checks++;
                if (avs_readdata !== exp) begin
                    failures++; $display("FAIL bp_data: got %h expected %h", avs_readdata, exp);
                end
            end
            if (busy_left == 0) begin
                q.push_back(status_in);
                accepted++;
                busy_left = RL;
            end else begin
                busy_left--;
            end
            @(negedge clk);
        end
        avs_read = 1'b0;
        for (int c = 0; c < int'(RL) + 3; c++) begin
            if (avs_readdatavalid) begin
                seen++;
                exp = (q.size() > 0) ? q.pop_front() : 64'hx;
                checks++;
                if (avs_readdata !== exp) begin
                    failures++; $display("FAIL bp_drain_data: got %h expected %h", avs_readdata, exp);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (seen != (6 + int'(RL)) / (int'(RL) + 1) || seen != accepted) begin
            failures++; $display("FAIL bp_count: got %0d returns expected %0d", seen, accepted);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] d; logic [1:0] r; int lat; bit p, to;
        bit saw_valid;
        do_op(0, 1, 1, 64'hDEAD_0000_CAFE_F00D, 8'hFF, d, r, lat, p, to);
        do_op(0, 1, 2, 64'h0000_0000_A5A5_5A5A, 8'hFF, d, r, lat, p, to);
        saw_valid = 1'b0;
        @(negedge clk);
        avs_address = 1; avs_read = 1'b1;
        @(posedge clk);
        #1;
        avs_read = 1'b0; rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (avs_readdatavalid) saw_valid = 1'b1;
        end
        checks++;
        if (avs_waitrequest !== 1'b1) begin
            failures++; $display("FAIL midrst_waitreq: got %b expected 1", avs_waitrequest);
        end
        rst = 1'b0;
        m_scratch = '0; m_fbm = '0;
        repeat (RL + 3) begin
            @(negedge clk);
            if (avs_readdatavalid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0 || fbm_ar !== 32'h0) begin
            failures++; $display("FAIL midrst_flush: got valid_seen=%b fbm=%h expected 0 and 0", saw_valid, fbm_ar);
        end
        do_op(1, 0, 1, '0, '0, d, r, lat, p, to);
        checks++;
        if (to || d !== 64'h0) begin
            failures++; $display("FAIL midrst_scratch: got %h expected 0", d);
        end
    endtask

    task automatic test_random();
        logic [63:0] d, wd, exp_d; logic [1:0] r, exp_r; int lat; bit p, to, rd, wr, exp_p;
        logic [AW-1:0] a;
        logic [7:0] be;
        int kind, sel;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            rd = (kind != 1); wr = (kind != 0);
            sel = $urandom_range(0, 9);
            a = (sel < 6) ? AW'(sel) : AW'($urandom_range(4, (1 << AW) - 1));
            wd = {$urandom, $urandom};
            be = 8'($urandom);
            status_in = {$urandom, $urandom};
            exp_d = m_read_data(a, status_in);
            exp_r = m_read_resp(a);
            exp_p = wr && m_pulse(a, be);
            if (wr) m_write(a, wd, be);
            do_op(rd, wr, a, wd, be, d, r, lat, p, to);
            checks++;
            if (to || p !== exp_p || fbm_ar !== m_fbm ||
                (rd && (d !== exp_d || r !== exp_r || lat != int'(RL)))) begin
                failures++;
                $display("FAIL rand_%0d: rd=%b wr=%b a=%h got data=%h resp=%b lat=%0d pulse=%b fbm=%h to=%b expected data=%h resp=%b pulse=%b fbm=%h",
                         i, rd, wr, a, d, r, lat, p, fbm_ar, to, exp_d, exp_r, exp_p, m_fbm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fbm_ar();
        test_byte_lanes();
        test_unused();
        test_write_then_read();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
